// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide, then sign fix-up.
module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] a_orig_q, a_orig_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        in_neg_a, in_neg_b;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // Magnitudes of the issuing operands; only signed ops (op[0]=0) take them.
   assign in_neg_a = ~op[0] & a[31];
   assign in_neg_b = ~op[0] & b[31];
   assign a_mag    = in_neg_a ? (~a + 32'd1) : a;
   assign b_mag    = in_neg_b ? (~b + 32'd1) : b;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);

   // Divide: acc = {remainder, dividend bits shifting into quotient}.
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_sub   = div_shift[31:0] - opnd_q;

   assign prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
   assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_orig_d = a_orig_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               op_d     = op;
               a_orig_d = a;
               neg_a_d  = in_neg_a;
               neg_b_d  = in_neg_b;
               cnt_d    = 6'd0;
               if (op[1]) begin
                  opnd_d = b_mag;
                  acc_d  = {32'd0, a_mag};
               end else begin
                  opnd_d = a_mag;
                  acc_d  = {32'd0, b_mag};
               end
               state_d = StCalc;
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end

         StCalc: begin
            if (op_q[1]) begin
               acc_d = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                              : {div_shift[31:0], acc_q[30:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = StFix;
         end

         StFix: begin
            if (op_q[1]) begin
               // Divide by zero bypasses sign fix: HI keeps the raw dividend.
               if (opnd_q == 32'd0) begin
                  hi_d = a_orig_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         op_q     <= 2'd0;
         a_orig_q <= 32'd0;
         opnd_q   <= 32'd0;
         acc_q    <= 64'd0;
         cnt_q    <= 6'd0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_orig_q <= a_orig_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic results, latency,
// MTHI/MTLO interplay, ignored starts and mid-operation reset.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mul_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one op in the next cycle and returns in its done cycle.
   // lat counts cycles from the start cycle (0) to the done cycle; inj>0
   // drives a stray start plus mthi in busy cycle inj.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int inj, input logic mt_start,
                         output int lat, output int bcnt);
      logic [31:0] hi0, lo0;
      @(negedge clk);
      hi0   = hi;
      lo0   = lo;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      mthi  = mt_start;
      mtlo  = mt_start;
      wdata = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'h0;
      check_eq({tag, "_hold_hi"}, hi, hi0);
      check_eq({tag, "_hold_lo"}, lo, lo0);
      lat  = 1;
      bcnt = 0;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         start = (lat == inj);
         mthi  = (lat == inj);
         wdata = 32'hCAFE_F00D;
         if (lat == inj) begin
            op = 2'b11;
            a  = 32'd100;
            b  = 32'd3;
         end
         @(posedge clk);
         #1;
         lat++;
         if (lat == inj + 1) check_eq({tag, "_mthi_busy"}, hi, hi0);
      end
      start = 1'b0;
      mthi  = 1'b0;
      check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
      check_eq({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_result(input string tag, input int lat, input int bcnt,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      check_eq({tag, "_hi"}, hi, exp_hi);
      check_eq({tag, "_lo"}, lo, exp_lo);
      check_eq({tag, "_latency"}, lat, 32'd34);
      check_eq({tag, "_busy_cycles"}, bcnt, 32'd33);
   endtask

   initial begin
      int lat, bcnt, ndone;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a     = 32'd0;
      b     = 32'd0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_hi", hi, 32'd0);
      check_eq("reset_lo", lo, 32'd0);
      check_eq("reset_busy", {31'd0, busy}, 32'd0);
      check_eq("reset_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, lat, bcnt);
      check_result("mult_neg", lat, bcnt, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      @(posedge clk);
      #1;
      check_eq("done_one_cycle", {31'd0, done}, 32'd0);

      // The following ops are issued back-to-back from each done cycle.
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, lat, bcnt);
      check_result("multu_max", lat, bcnt, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_m1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, lat, bcnt);
      check_result("mult_m1", lat, bcnt, 32'h0000_0000, 32'h0000_0001);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, lat, bcnt);
      check_result("div_neg", lat, bcnt, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", 2'b11, 32'd7, 32'd2, 0, 1'b0, lat, bcnt);
      check_result("divu", lat, bcnt, 32'd1, 32'd3);
      run_op("divu_zero", 2'b11, 32'd100, 32'd0, 0, 1'b0, lat, bcnt);
      check_result("divu_zero", lat, bcnt, 32'h0000_0064, 32'hFFFF_FFFF);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat, bcnt);
      check_result("div_ovf", lat, bcnt, 32'h0000_0000, 32'h8000_0000);
      run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 0, 1'b0, lat, bcnt);
      check_result("div_zero_neg", lat, bcnt, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // Stray start and mthi five cycles into busy must leave 6*7 untouched.
      run_op("start_busy", 2'b01, 32'd6, 32'd7, 5, 1'b0, lat, bcnt);
      check_result("start_busy", lat, bcnt, 32'd0, 32'd42);
      @(posedge clk);
      #1;
      check_eq("no_queued_busy", {31'd0, busy}, 32'd0);
      check_eq("no_queued_done", {31'd0, done}, 32'd0);

      // mthi/mtlo alongside start are ignored.
      run_op("mt_with_start", 2'b01, 32'd2, 32'd3, 0, 1'b1, lat, bcnt);
      check_result("mt_with_start", lat, bcnt, 32'd0, 32'd6);

      @(negedge clk);
      mtlo  = 1'b1;
      wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      mtlo = 1'b0;
      check_eq("mtlo_idle_lo", lo, 32'h0000_1234);
      check_eq("mtlo_idle_hi", hi, 32'd0);
      @(negedge clk);
      mthi  = 1'b1;
      wdata = 32'h0000_ABCD;
      @(posedge clk);
      #1;
      mthi = 1'b0;
      check_eq("mthi_idle_hi", hi, 32'h0000_ABCD);
      check_eq("mthi_idle_lo", lo, 32'h0000_1234);

      // Reset ten cycles into a DIV aborts without writing a result.
      @(negedge clk);
      start = 1'b1;
      op    = 2'b10;
      a     = 32'hFFFF_FFF9;
      b     = 32'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_done", {31'd0, done}, 32'd0);
      check_eq("abort_hi", hi, 32'd0);
      check_eq("abort_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check_eq("abort_no_done", ndone, 32'd0);
      check_eq("abort_idle", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
